// File: rtl/uart_rx_byte_if.sv
// Byte-receiver bundle: serial line and enable in, received byte and
// status pulses out. The receiver uses the slave view; whoever drives the
// line and consumes the bytes uses the master view.
interface uart_rx_byte_if;
  logic       RxEn;      // receive enable, 0 = idle/abort
  logic       Rx;        // asynchronous serial line, idle high, 8N1 LSB first
  logic [7:0] RxData;    // last correctly framed byte
  logic       RxDone;    // one-cycle pulse, RxData valid this cycle
  logic       FrameErr;  // one-cycle pulse, stop bit sampled low
  logic       RxBusy;    // receiver not in IDLE

  modport slave (
    input  RxEn,
    input  Rx,
    output RxData,
    output RxDone,
    output FrameErr,
    output RxBusy
  );

  modport master (
    output RxEn,
    output Rx,
    input  RxData,
    input  RxDone,
    input  FrameErr,
    input  RxBusy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
// The serial line is double-flopped before any decision is made. A falling
// edge in IDLE starts a frame; the start bit is re-checked half a bit later
// so that short glitches are dropped without any status pulse. From that
// mid-start point every data bit and the stop bit are sampled one full bit
// period apart, i.e. near the centre of each bit. A low stop bit raises a
// single FrameErr and parks the receiver in WAITHI until the line returns
// high, so a held-low break reports exactly one error.
// RxData only changes on a good frame (or reset) and is held otherwise.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434  // clk cycles per bit, 4..65535
) (
  input  logic          clk,
  input  logic          Rst,   // synchronous, active-high
  uart_rx_byte_if.slave rx_if
);

  // Count at which the start bit is re-checked (middle of the start bit).
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
  // Count at which data and stop bits are sampled (one bit after last sample).
  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_WAITHI = 3'd4
  } state_t;

  // Synchronizer flops; both reset high to match the idle line level.
  logic        rx_meta_q;
  logic        rx_sync_q;

  // Receiver state.
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;

  // Registered outputs.
  logic [7:0]  rx_data_q;
  logic        rx_done_q;
  logic        frame_err_q;

  // Combinational helpers derived from the registers.
  logic        rx_s;        // synchronized line value used for every decision
  logic [15:0] cnt_d;       // counter value for the "keep counting" case
  logic        half_hit_d;  // start-bit re-check point reached
  logic        full_hit_d;  // data/stop sample point reached

  assign rx_s       = rx_sync_q;
  assign cnt_d      = cnt_q + 16'd1;
  assign half_hit_d = (cnt_q == HALF_CNT);
  assign full_hit_d = (cnt_q == FULL_CNT);

  // Two-flop synchronizer bringing the asynchronous line into the clk domain.
  always_ff @(posedge clk) begin
    if (Rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_if.Rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Frame FSM: bit timing, data capture, output byte and status pulses.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;

      if (!rx_if.RxEn) begin
        // Abort: drop any frame in progress, keep the last good byte.
        state_q   <= ST_IDLE;
        cnt_q     <= 16'd0;
        bit_idx_q <= 3'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            if (!rx_s) begin
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end

          ST_START: begin
            if (half_hit_d) begin
              cnt_q     <= 16'd0;
              bit_idx_q <= 3'd0;
              if (!rx_s) begin
                state_q <= ST_DATA;
              end else begin
                // Line went back high: treat as a glitch, no pulse.
                state_q <= ST_IDLE;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end

          ST_DATA: begin
            if (full_hit_d) begin
              shift_q[bit_idx_q] <= rx_s;
              cnt_q              <= 16'd0;
              if (bit_idx_q == 3'd7) begin
                bit_idx_q <= 3'd0;
                state_q   <= ST_STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end

          ST_STOP: begin
            if (full_hit_d) begin
              cnt_q <= 16'd0;
              if (rx_s) begin
                // Good frame: publish the byte together with the pulse.
                rx_data_q <= shift_q;
                rx_done_q <= 1'b1;
                state_q   <= ST_IDLE;
              end else begin
                // Bad stop bit: report once, then wait for the line to idle.
                frame_err_q <= 1'b1;
                state_q     <= ST_WAITHI;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end

          ST_WAITHI: begin
            cnt_q <= 16'd0;
            if (rx_s) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAITHI;
            end
          end

          default: begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
          end
        endcase
      end
    end
  end

  assign rx_if.RxData   = rx_data_q;
  assign rx_if.RxDone   = rx_done_q;
  assign rx_if.FrameErr = frame_err_q;
  assign rx_if.RxBusy   = (state_q != ST_IDLE);

endmodule
